// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: multi-cycle load-use and branch stalls plus memory-busy freeze.
// Optional stall-cycle performance counter enabled by defining HAZARD_STALL_PERF_EN.
module hazard_stall_ctrl #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int BR_LAT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] IfIdRs1,
    input  logic [REG_AW-1:0] IfIdRs2,
    input  logic              IfId_UseRs2,
    input  logic              IfId_Branch,
    input  logic [REG_AW-1:0] IdExRd,
    input  logic              IdEx_MemRead,
    input  logic              Mem_Stall,
    output logic              Pc_Write,
    output logic              IfId_Write,
    output logic              IfId_Flush,
    output logic              Ctrl_Flush,
    output logic              Pipe_Freeze,
    output logic [31:0]       Stall_Cnt
);

    localparam int MAX_LAT = (LOAD_LAT > BR_LAT) ? LOAD_LAT : BR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] LD_INIT  = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] BR_INIT  = CNT_W'(BR_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LD_STALL = 2'd1,
        BR_STALL = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             lu_s;

    // Register zero never carries a real dependency, so it is excluded.
    assign lu_s = IdEx_MemRead && (IdExRd != {REG_AW{1'b0}}) &&
                  ((IdExRd == IfIdRs1) || (IfId_UseRs2 && (IdExRd == IfIdRs2)));

    // State and stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and counter update; a memory freeze holds everything
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (Mem_Stall) begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (lu_s) begin
                        if (LOAD_LAT > 1) begin
                            state_nxt_s = LD_STALL;
                            cnt_nxt_s   = LD_INIT;
                        end else begin
                            state_nxt_s = RUN;
                            cnt_nxt_s   = CNT_ZERO;
                        end
                    end else if (IfId_Branch) begin
                        if (BR_LAT > 1) begin
                            state_nxt_s = BR_STALL;
                            cnt_nxt_s   = BR_INIT;
                        end else begin
                            state_nxt_s = RUN;
                            cnt_nxt_s   = CNT_ZERO;
                        end
                    end else begin
                        state_nxt_s = RUN;
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                LD_STALL, BR_STALL: begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Pipeline control outputs, combinational so a hazard stalls in its own cycle
    always_comb begin
        Pc_Write    = 1'b1;
        IfId_Write  = 1'b1;
        IfId_Flush  = 1'b0;
        Ctrl_Flush  = 1'b0;
        Pipe_Freeze = 1'b0;
        if (rst) begin
            Pc_Write   = 1'b0;
            IfId_Write = 1'b0;
        end else if (Mem_Stall) begin
            Pc_Write    = 1'b0;
            IfId_Write  = 1'b0;
            Pipe_Freeze = 1'b1;
        end else begin
            case (state_r)
                LD_STALL: begin
                    Pc_Write   = 1'b0;
                    IfId_Write = 1'b0;
                    Ctrl_Flush = 1'b1;
                end
                BR_STALL: begin
                    Pc_Write   = 1'b0;
                    IfId_Flush = 1'b1;
                end
                RUN: begin
                    if (lu_s) begin
                        Pc_Write   = 1'b0;
                        IfId_Write = 1'b0;
                        Ctrl_Flush = 1'b1;
                    end else if (IfId_Branch) begin
                        Pc_Write   = 1'b0;
                        IfId_Flush = 1'b1;
                    end else begin
                        Pc_Write   = 1'b1;
                    end
                end
                default: begin
                    Pc_Write   = 1'b0;
                    IfId_Write = 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] perf_cnt_r;
    logic        stall_s;

    assign stall_s = !Mem_Stall && ((state_r != RUN) || lu_s || IfId_Branch);

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_r <= 32'd0;
        end else if (stall_s && (perf_cnt_r != 32'hFFFF_FFFF)) begin
            perf_cnt_r <= perf_cnt_r + 32'd1;
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign Stall_Cnt = rst ? 32'd0 : perf_cnt_r;
`else
    assign Stall_Cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share stimulus
// and are checked every cycle against a pending-stall model.
module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use2, br, memrd, mem;

    logic a_pcw, a_ifw, a_iff, a_cf, a_frz;
    logic b_pcw, b_ifw, b_iff, b_cf, b_frz;
    logic [31:0] a_sc, b_sc;

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .IfIdRs1(rs1), .IfIdRs2(rs2), .IfId_UseRs2(use2),
        .IfId_Branch(br), .IdExRd(rd), .IdEx_MemRead(memrd), .Mem_Stall(mem),
        .Pc_Write(a_pcw), .IfId_Write(a_ifw), .IfId_Flush(a_iff), .Ctrl_Flush(a_cf),
        .Pipe_Freeze(a_frz), .Stall_Cnt(a_sc)
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .IfIdRs1(rs1), .IfIdRs2(rs2), .IfId_UseRs2(use2),
        .IfId_Branch(br), .IdExRd(rd), .IdEx_MemRead(memrd), .Mem_Stall(mem),
        .Pc_Write(b_pcw), .IfId_Write(b_ifw), .IfId_Flush(b_iff), .Ctrl_Flush(b_cf),
        .Pipe_Freeze(b_frz), .Stall_Cnt(b_sc)
    );

`ifdef HAZARD_STALL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {Pc_Write, IfId_Write, IfId_Flush, Ctrl_Flush, Pipe_Freeze}
    localparam logic [4:0] NOM  = 5'b11000;
    localparam logic [4:0] LDV  = 5'b00010;
    localparam logic [4:0] BRV  = 5'b01100;
    localparam logic [4:0] FRZ  = 5'b00001;
    localparam logic [4:0] RSTV = 5'b00000;

    typedef struct {
        int          inst;
        logic [4:0]  ctl;
        logic [31:0] sc;
    } exp_t;

    exp_t        sbq[$];
    int          ll[2] = '{1, 3};
    int          bl    = 2;
    int          ld_left[2] = '{0, 0};
    int          br_left[2] = '{0, 0};
    logic [31:0] perf[2] = '{32'd0, 32'd0};
    int          checks = 0;
    int          errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: model expectation -> queue, sample at negedge, advance model at posedge.
    task automatic step();
        logic        lu;
        logic        stall;
        exp_t        e, o;
        int          nl[2], nb[2];
        logic [31:0] np[2];
        logic [4:0]  got_ctl;
        logic [31:0] got_sc;
        lu = memrd && (rd != 5'd0) && ((rd == rs1) || (use2 && (rd == rs2)));
        for (int k = 0; k < 2; k++) begin
            nl[k] = ld_left[k];
            nb[k] = br_left[k];
            np[k] = perf[k];
            stall = 1'b0;
            e.inst = k;
            if (rst) begin
                e.ctl = RSTV;
                e.sc  = 32'd0;
                nl[k] = 0;
                nb[k] = 0;
                np[k] = 32'd0;
            end else begin
                e.sc = PERF ? perf[k] : 32'd0;
                if (mem) begin
                    e.ctl = FRZ;
                end else if (ld_left[k] > 0) begin
                    e.ctl = LDV; nl[k] = ld_left[k] - 1; stall = 1'b1;
                end else if (br_left[k] > 0) begin
                    e.ctl = BRV; nb[k] = br_left[k] - 1; stall = 1'b1;
                end else if (lu) begin
                    e.ctl = LDV; nl[k] = ll[k] - 1; stall = 1'b1;
                end else if (br) begin
                    e.ctl = BRV; nb[k] = bl - 1; stall = 1'b1;
                end else begin
                    e.ctl = NOM;
                end
                if (stall && (np[k] != 32'hFFFF_FFFF)) np[k] = np[k] + 32'd1;
            end
            sbq.push_back(e);
        end
        @(negedge clk);
        while (sbq.size() > 0) begin
            o = sbq.pop_front();
            got_ctl = (o.inst == 0) ? {a_pcw, a_ifw, a_iff, a_cf, a_frz}
                                    : {b_pcw, b_ifw, b_iff, b_cf, b_frz};
            got_sc  = (o.inst == 0) ? a_sc : b_sc;
            chk_eq($sformatf("ctl_%0d", o.inst), {27'd0, got_ctl}, {27'd0, o.ctl});
            chk_eq($sformatf("stall_cnt_%0d", o.inst), got_sc, o.sc);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            ld_left[k] = nl[k];
            br_left[k] = nb[k];
            perf[k]    = np[k];
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use2 = 1'b0; br = 1'b0; memrd = 1'b0; mem = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (2) step();

        // load to $8, dependent read of $8; load leaves EX after one cycle
        rd = 5'd8; memrd = 1'b1; rs1 = 5'd8; step();
        memrd = 1'b0; rd = 5'd0; repeat (4) step();

        // $0 never hazards; rs2 match only counts when rs2 is read
        rd = 5'd0; rs1 = 5'd0; memrd = 1'b1; step();
        rd = 5'd9; rs1 = 5'd3; rs2 = 5'd9; use2 = 1'b0; step();
        use2 = 1'b1; step();
        memrd = 1'b0; rd = 5'd0; use2 = 1'b0; repeat (3) step();

        // plain branch
        br = 1'b1; step();
        br = 1'b0; repeat (3) step();

        // load-use and branch together; branch held in IF/ID while stalled
        rd = 5'd8; memrd = 1'b1; rs1 = 5'd8; br = 1'b1; step();
        memrd = 1'b0; rd = 5'd0; repeat (3) step();
        br = 1'b0; repeat (3) step();

        // memory freeze in the middle of a load stall
        rd = 5'd8; memrd = 1'b1; rs1 = 5'd8; step();
        memrd = 1'b0; rd = 5'd0; mem = 1'b1; repeat (2) step();
        mem = 1'b0; repeat (3) step();

        // reset during a branch stall
        br = 1'b1; step();
        br = 1'b0; rst = 1'b1; step();
        rst = 1'b0; repeat (2) step();

        // clean count: 3 load stalls then 2 branch stalls (instance b)
        rst = 1'b1; step(); rst = 1'b0;
        rd = 5'd8; memrd = 1'b1; rs1 = 5'd8; step();
        memrd = 1'b0; rd = 5'd0; repeat (2) step();
        br = 1'b1; step();
        br = 1'b0; repeat (2) step();

        // random mix
        for (int i = 0; i < 80; i++) begin
            rd    = 5'($urandom_range(0, 3));
            rs1   = 5'($urandom_range(0, 3));
            rs2   = 5'($urandom_range(0, 3));
            use2  = 1'($urandom_range(0, 1));
            memrd = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 3) == 0);
            mem   = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 30) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised pipeline hazard/stall controller for the 5-stage MIPS core. Sits beside the forwarding logic and drives PC, IF/ID and ID/EX control.
- Handles multi-cycle load-use stalls (configurable load latency) and branch stalls until the outcome is resolved (configurable branch latency).
- Handles a global pipeline freeze from an external memory-busy signal.
- Uses a small FSM and a down-counter, so stalls longer than one cycle survive after the producing load has left ID/EX.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, total stall cycles per load-use hazard (>=1).
- BR_LAT, 2, total stall cycles per branch/jump in ID (>=1).
- CNT_W, $clog2(max(LOAD_LAT,BR_LAT)+1), stall counter width (derived, not overridden).

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- IfIdRs1  input  REG_AW  rs of the instruction in ID.
- IfIdRs2  input  REG_AW  rt of the instruction in ID.
- IfId_UseRs2  input  1  ID instruction actually reads rs2 (0 for I-type, which ignores rs2 match).
- IfId_Branch  input  1  ID instruction is a branch/jump.
- IdExRd  input  REG_AW  destination of the instruction in EX.
- IdEx_MemRead  input  1  EX instruction is a load.
- Mem_Stall  input  1  data memory busy; freeze the whole pipeline.
- Pc_Write  output  1  1 = PC updates this cycle.
- IfId_Write  output  1  1 = IF/ID register loads.
- IfId_Flush  output  1  1 = IF/ID loads a NOP (valid only when IfId_Write=1).
- Ctrl_Flush  output  1  1 = zero the control bits entering ID/EX (bubble).
- Pipe_Freeze  output  1  1 = hold all pipeline registers, including ID/EX, EX/MEM and MEM/WB.
- Stall_Cnt  output  32  stall-cycle performance counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: state=RUN, cnt=0.
- Outputs while rst=1: Pc_Write=0, IfId_Write=0, IfId_Flush=0, Ctrl_Flush=0, Pipe_Freeze=0, Stall_Cnt=0.
- Outputs are combinational from state, cnt and inputs. No added latency; a hazard stalls in the same cycle it is detected.
- Load-use detect, LU: IdEx_MemRead && IdExRd!=0 && (IdExRd==IfIdRs1 || (IfId_UseRs2 && IdExRd==IfIdRs2)).
- Priority: rst > Mem_Stall > active stall state > LU > IfId_Branch.
- Mem_Stall=1, in any state:
  - Pipe_Freeze=1, Pc_Write=0, IfId_Write=0, Ctrl_Flush=0, IfId_Flush=0.
  - state and cnt hold; no decrement.
- Nominal (RUN, no hazard): Pc_Write=1, IfId_Write=1, IfId_Flush=0, Ctrl_Flush=0, Pipe_Freeze=0.
- RUN and LU:
  - Pc_Write=0, IfId_Write=0, Ctrl_Flush=1.
  - If LOAD_LAT>1: next state=LD_STALL, cnt=LOAD_LAT-1. Otherwise stay in RUN.
- LD_STALL:
  - Same outputs as RUN+LU.
  - cnt decrements each cycle; when cnt==1, next state=RUN.
  - LU and IfId_Branch are ignored in this state.
- RUN and !LU and IfId_Branch:
  - Pc_Write=0, IfId_Write=1, IfId_Flush=1, Ctrl_Flush=0. The branch advances; the wrong-path fetch is squashed.
  - If BR_LAT>1: next state=BR_STALL, cnt=BR_LAT-1.
- BR_STALL:
  - Same outputs as the branch cycle; cnt decrements; when cnt==1, next state=RUN.
  - The following cycle in RUN resumes with Pc_Write=1; the PC source mux already holds the resolved target.
- LU and IfId_Branch together: LU wins. The branch stays held in IF/ID and is re-detected once the load stall ends.
- Reset mid-stall: state returns to RUN, cnt=0 on the next edge; no partial stall remains.
- Stall cycle definition: a cycle with state!=RUN or (state==RUN && (LU||IfId_Branch)), excluding Mem_Stall cycles.

Optional Feature:
- Macro: HAZARD_STALL_PERF_EN.
- Defined: Stall_Cnt increments by 1 every stall cycle and saturates at 32'hFFFF_FFFF. Cleared by rst.
- Undefined: Stall_Cnt is tied to 32'd0 and no counter flops are built.

Test Plan:
- LOAD_LAT=1: load to $8 in EX, ID reads rs=$8 -> exactly 1 cycle with Pc_Write=0, IfId_Write=0, Ctrl_Flush=1; then nominal.
- LOAD_LAT=3: same hazard -> 3 consecutive stall cycles even though IdEx_MemRead drops after cycle 1; state RUN on cycle 4.
- IdExRd=0 with IfIdRs1=0 and IdEx_MemRead=1 -> no stall. Rs2 match with IfId_UseRs2=0 -> no stall.
- BR_LAT=2, IfId_Branch=1 -> 2 cycles of Pc_Write=0, IfId_Flush=1, IfId_Write=1; LU in the same first cycle -> load stall first, then the 2 branch cycles.
- LOAD_LAT=3, Mem_Stall=1 for 2 cycles during LD_STALL with cnt=2 -> Pipe_Freeze=1, cnt holds at 2; after release, 2 further stall cycles.
- rst during BR_STALL -> outputs at reset values that cycle, RUN next. With HAZARD_STALL_PERF_EN: 3 load plus 2 branch stall cycles -> Stall_Cnt=5.
